// File: rtl/banco_reg_param.sv
`default_nettype none
// ============================================================================
//  Module   : banco_reg_param
//  Purpose  : Parametrised register file for the pipelined RV32I-style core.
//             It has NUM_LEIT combinational read ports and two write ports.
//             Write port 1 has priority over write port 0. A busy bit per
//             register (the scoreboard) is set by decode reservations and
//             cleared by writeback. Register 0 is hardwired to zero and is
//             never busy.
//
//  Ports    : sinal_clk     - clock; writes, reserves and releases on rising edge
//             sinal_rst_n   - asynchronous active-low reset
//             sel_leit      - read selectors, port k at [k*LARG_END +: LARG_END]
//             dado_leit     - read data, port k at [k*LARG_DADO +: LARG_DADO]
//             ocupado_leit  - busy flag of the selected register, per read port
//             hab_esc0/dest_esc0/dado_esc0 - write port 0
//             hab_esc1/dest_esc1/dado_esc1 - write port 1 (wins on collision)
//             hab_reserva/dest_reserva     - mark a register busy
//             num_ocupados  - registered count of busy registers
//
//  Options  : BANCO_REG_BYPASS_EN - when defined, same-cycle write-to-read
//             forwarding on every read port.
//
//  Revision : 1.0 - initial parametrised release
// ============================================================================
module banco_reg_param #(
    parameter int LARG_DADO = 32,
    parameter int NUM_REGS  = 32,
    parameter int NUM_LEIT  = 2,
    localparam int LARG_END = $clog2(NUM_REGS)
) (
    input  logic                          sinal_clk,
    input  logic                          sinal_rst_n,
    input  logic [NUM_LEIT*LARG_END-1:0]  sel_leit,
    output logic [NUM_LEIT*LARG_DADO-1:0] dado_leit,
    output logic [NUM_LEIT-1:0]           ocupado_leit,
    input  logic                          hab_esc0,
    input  logic [LARG_END-1:0]           dest_esc0,
    input  logic [LARG_DADO-1:0]          dado_esc0,
    input  logic                          hab_esc1,
    input  logic [LARG_END-1:0]           dest_esc1,
    input  logic [LARG_DADO-1:0]          dado_esc1,
    input  logic                          hab_reserva,
    input  logic [LARG_END-1:0]           dest_reserva,
    output logic [LARG_END:0]             num_ocupados
);

    localparam logic [LARG_END-1:0] c_END_ZERO = '0;

    logic [LARG_DADO-1:0] r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]  r_ocupado;
    logic [LARG_END:0]    r_num_ocupados;

    logic                 w_esc1_ef;
    logic                 w_esc0_ef;
    logic                 w_res_ef;
    logic [NUM_REGS-1:0]  w_ocupado_prox;
    logic [LARG_END:0]    w_num_prox;

    // Port 0 is suppressed when port 1 hits the same register. This keeps the
    // two array writes disjoint, so their order in the sequential block does
    // not matter.
    assign w_esc1_ef = hab_esc1 && (dest_esc1 != c_END_ZERO);
    assign w_esc0_ef = hab_esc0 && (dest_esc0 != c_END_ZERO) &&
                       !(w_esc1_ef && (dest_esc1 == dest_esc0));
    assign w_res_ef  = hab_reserva && (dest_reserva != c_END_ZERO);

    // Next scoreboard state. The reservation is applied last, so a new
    // producer issuing on the same edge as a release keeps the register busy.
    always_comb begin
        w_ocupado_prox = r_ocupado;
        if (w_esc0_ef) w_ocupado_prox[dest_esc0] = 1'b0;
        if (w_esc1_ef) w_ocupado_prox[dest_esc1] = 1'b0;
        if (w_res_ef)  w_ocupado_prox[dest_reserva] = 1'b1;
        w_ocupado_prox[0] = 1'b0;
    end

    // The count is the population count of the next busy vector, not an
    // up/down counter. It therefore cannot drift or wrap, and it is at most
    // NUM_REGS-1.
    always_comb begin
        w_num_prox = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_num_prox = w_num_prox + {{LARG_END{1'b0}}, w_ocupado_prox[i]};
        end
    end

    always_ff @(posedge sinal_clk or negedge sinal_rst_n) begin
        if (!sinal_rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_ocupado      <= '0;
            r_num_ocupados <= '0;
        end else begin
            if (w_esc0_ef) r_regs[dest_esc0] <= dado_esc0;
            if (w_esc1_ef) r_regs[dest_esc1] <= dado_esc1;
            r_ocupado      <= w_ocupado_prox;
            r_num_ocupados <= w_num_prox;
        end
    end

    assign num_ocupados = r_num_ocupados;

    for (genvar k = 0; k < NUM_LEIT; k++) begin : g_leit
        logic [LARG_END-1:0]  w_sel;
        logic [LARG_DADO-1:0] w_dado;
        logic                 w_ocup;

        assign w_sel = sel_leit[k*LARG_END +: LARG_END];

        always_comb begin
            w_dado = '0;
            w_ocup = 1'b0;
            if (w_sel != c_END_ZERO) begin
                w_dado = r_regs[w_sel];
                w_ocup = r_ocupado[w_sel];
`ifdef BANCO_REG_BYPASS_EN
                // Forward the value being written this cycle. The register is
                // no longer busy once it is written, unless a new reservation
                // is issued for it in the same cycle.
                if (w_esc1_ef && (dest_esc1 == w_sel)) begin
                    w_dado = dado_esc1;
                    w_ocup = w_res_ef && (dest_reserva == w_sel);
                end else if (w_esc0_ef && (dest_esc0 == w_sel)) begin
                    w_dado = dado_esc0;
                    w_ocup = w_res_ef && (dest_reserva == w_sel);
                end
`endif
            end
        end

        assign dado_leit[k*LARG_DADO +: LARG_DADO] = w_dado;
        assign ocupado_leit[k]                      = w_ocup;
    end

endmodule
`default_nettype wire

// File: tb/tb_banco_reg_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_banco_reg_param
//  Purpose  : Directed self-checking bench for banco_reg_param with default
//             parameters. Expected values are queued as the stimulus is
//             driven, then popped and compared against DUT outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_banco_reg_param;

    localparam int LD = 32;
    localparam int NR = 32;
    localparam int NL = 2;
    localparam int LE = 5;

`ifdef BANCO_REG_BYPASS_EN
    localparam bit c_BYPASS = 1'b1;
`else
    localparam bit c_BYPASS = 1'b0;
`endif

    logic             sinal_clk = 1'b0;
    logic             sinal_rst_n;
    logic [NL*LE-1:0] sel_leit;
    logic [NL*LD-1:0] dado_leit;
    logic [NL-1:0]    ocupado_leit;
    logic             hab_esc0, hab_esc1, hab_reserva;
    logic [LE-1:0]    dest_esc0, dest_esc1, dest_reserva;
    logic [LD-1:0]    dado_esc0, dado_esc1;
    logic [LE:0]      num_ocupados;

    banco_reg_param #(.LARG_DADO(LD), .NUM_REGS(NR), .NUM_LEIT(NL)) dut (
        .sinal_clk    (sinal_clk),
        .sinal_rst_n  (sinal_rst_n),
        .sel_leit     (sel_leit),
        .dado_leit    (dado_leit),
        .ocupado_leit (ocupado_leit),
        .hab_esc0     (hab_esc0),
        .dest_esc0    (dest_esc0),
        .dado_esc0    (dado_esc0),
        .hab_esc1     (hab_esc1),
        .dest_esc1    (dest_esc1),
        .dado_esc1    (dado_esc1),
        .hab_reserva  (hab_reserva),
        .dest_reserva (dest_reserva),
        .num_ocupados (num_ocupados)
    );

    always #5 sinal_clk = ~sinal_clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } sb_item_t;

    sb_item_t sb[$];
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic push(input string tag, input logic [31:0] val);
        sb_item_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        sb_item_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: observed %h, nothing expected", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge sinal_clk);
        #1;
    endtask

    task automatic idle();
        hab_esc0 = 1'b0; dest_esc0 = '0; dado_esc0 = '0;
        hab_esc1 = 1'b0; dest_esc1 = '0; dado_esc1 = '0;
        hab_reserva = 1'b0; dest_reserva = '0;
    endtask

    task automatic rd(input logic [LE-1:0] s0, input logic [LE-1:0] s1);
        sel_leit = {s1, s0};
    endtask

    function automatic logic [31:0] d0();
        return dado_leit[31:0];
    endfunction
    function automatic logic [31:0] d1();
        return dado_leit[63:32];
    endfunction
    function automatic logic [31:0] num();
        return {26'd0, num_ocupados};
    endfunction

    initial begin
        idle();
        sel_leit    = '0;
        sinal_rst_n = 1'b0;

        // Reset state.
        #2;
        rd(5'd5, 5'd6); #1;
        push("rst_dado0", 32'h0); chk(d0());
        push("rst_ocup1", 32'h0); chk({31'd0, ocupado_leit[1]});
        push("rst_num",   32'h0); chk(num());
        @(negedge sinal_clk);
        sinal_rst_n = 1'b1;
        tick();

        // Write x5 and reserve x6, then assert reset asynchronously mid-cycle.
        hab_esc0 = 1'b1; dest_esc0 = 5'd5; dado_esc0 = 32'hDEADBEEF;
        hab_reserva = 1'b1; dest_reserva = 5'd6;
        tick(); idle();
        rd(5'd5, 5'd6); #1;
        push("x5_written", 32'hDEADBEEF); chk(d0());
        push("x6_busy",    32'h1);        chk({31'd0, ocupado_leit[1]});
        push("num_one",    32'h1);        chk(num());
        sinal_rst_n = 1'b0; #1;
        push("async_rst_dado", 32'h0); chk(d0());
        push("async_rst_ocup", 32'h0); chk({31'd0, ocupado_leit[1]});
        push("async_rst_num",  32'h0); chk(num());
        #2 sinal_rst_n = 1'b1;
        tick();

        // Register 0 ignores writes and reservations.
        hab_esc0 = 1'b1; dest_esc0 = 5'd0; dado_esc0 = 32'hFFFFFFFF;
        hab_reserva = 1'b1; dest_reserva = 5'd0;
        tick(); idle();
        rd(5'd0, 5'd0); #1;
        push("x0_dado", 32'h0); chk(d0());
        push("x0_ocup", 32'h0); chk({31'd0, ocupado_leit[0]});
        push("x0_num",  32'h0); chk(num());

        // Both ports target x7; port 1 wins.
        hab_esc0 = 1'b1; dest_esc0 = 5'd7; dado_esc0 = 32'h11111111;
        hab_esc1 = 1'b1; dest_esc1 = 5'd7; dado_esc1 = 32'h22222222;
        tick(); idle();
        rd(5'd7, 5'd0); #1;
        push("collision_x7", 32'h22222222); chk(d0());

        // Scoreboard: reserve x3, then x4, then x3 again.
        hab_reserva = 1'b1; dest_reserva = 5'd3; tick();
        dest_reserva = 5'd4; tick();
        dest_reserva = 5'd3; tick(); idle();
        rd(5'd3, 5'd4); #1;
        push("x3_busy",  32'h1); chk({31'd0, ocupado_leit[0]});
        push("x4_busy",  32'h1); chk({31'd0, ocupado_leit[1]});
        push("num_two",  32'h2); chk(num());

        // Release and reserve x3 on the same edge: the reservation wins.
        hab_esc0 = 1'b1; dest_esc0 = 5'd3; dado_esc0 = 32'h33333333;
        hab_reserva = 1'b1; dest_reserva = 5'd3;
        tick(); idle(); #1;
        push("x3_still_busy", 32'h1);        chk({31'd0, ocupado_leit[0]});
        push("num_still_two", 32'h2);        chk(num());
        push("x3_data",       32'h33333333); chk(d0());

        // Release x3 and x4 on the same edge.
        hab_esc0 = 1'b1; dest_esc0 = 5'd3; dado_esc0 = 32'h000000A3;
        hab_esc1 = 1'b1; dest_esc1 = 5'd4; dado_esc1 = 32'h000000B4;
        tick(); idle(); #1;
        push("release2_num", 32'h0);  chk(num());
        push("x3_free",      32'h0);  chk({31'd0, ocupado_leit[0]});
        push("x4_free",      32'h0);  chk({31'd0, ocupado_leit[1]});
        push("x3_relval",    32'hA3); chk(d0());
        push("x4_relval",    32'hB4); chk(d1());

        // Forwarding: x9 holds an old value and is busy; write a new value while reading it.
        hab_esc0 = 1'b1; dest_esc0 = 5'd9; dado_esc0 = 32'h12345678;
        hab_reserva = 1'b1; dest_reserva = 5'd9;
        tick(); idle();
        hab_esc0 = 1'b1; dest_esc0 = 5'd9; dado_esc0 = 32'hCAFEF00D;
        rd(5'd9, 5'd0); #1;
        push("same_cycle_x9_dado", c_BYPASS ? 32'hCAFEF00D : 32'h12345678); chk(d0());
        push("same_cycle_x9_ocup", c_BYPASS ? 32'h0 : 32'h1);               chk({31'd0, ocupado_leit[0]});
        tick(); idle(); #1;
        push("next_cycle_x9_dado", 32'hCAFEF00D); chk(d0());
        push("next_cycle_x9_ocup", 32'h0);        chk({31'd0, ocupado_leit[0]});
        push("x9_num",             32'h0);        chk(num());

        // Forwarding priority on port 1, with a reservation to the same register.
        hab_esc0 = 1'b1; dest_esc0 = 5'd10; dado_esc0 = 32'h0A0A0A0A;
        hab_esc1 = 1'b1; dest_esc1 = 5'd10; dado_esc1 = 32'h5555AAAA;
        hab_reserva = 1'b1; dest_reserva = 5'd10;
        rd(5'd0, 5'd10); #1;
        push("same_cycle_x10_dado", c_BYPASS ? 32'h5555AAAA : 32'h0); chk(d1());
        push("same_cycle_x10_ocup", c_BYPASS ? 32'h1 : 32'h0);        chk({31'd0, ocupado_leit[1]});
        push("port0_rd_x0",         32'h0);                           chk(d0());
        tick(); idle(); #1;
        push("next_cycle_x10_dado", 32'h5555AAAA); chk(d1());
        push("next_cycle_x10_ocup", 32'h1);        chk({31'd0, ocupado_leit[1]});
        push("x10_num",             32'h1);        chk(num());

        // Fill the scoreboard: reserve x1..x31 (x10 is already busy).
        for (int i = 1; i < NR; i++) begin
            hab_reserva = 1'b1; dest_reserva = LE'(i);
            tick();
        end
        idle(); #1;
        push("num_full", 32'd31); chk(num());

        // Release two registers and re-reserve an already-busy one: delta -2.
        hab_esc0 = 1'b1; dest_esc0 = 5'd1; dado_esc0 = 32'h1;
        hab_esc1 = 1'b1; dest_esc1 = 5'd2; dado_esc1 = 32'h2;
        hab_reserva = 1'b1; dest_reserva = 5'd10;
        tick(); idle(); #1;
        push("num_minus2", 32'd29); chk(num());

        // Release two registers and re-reserve a free one: net delta -1.
        hab_esc0 = 1'b1; dest_esc0 = 5'd3; dado_esc0 = 32'h3;
        hab_esc1 = 1'b1; dest_esc1 = 5'd4; dado_esc1 = 32'h4;
        hab_reserva = 1'b1; dest_reserva = 5'd1;
        tick(); idle();
        rd(5'd1, 5'd2); #1;
        push("num_minus1",  32'd28); chk(num());
        push("x1_rebusy",   32'h1);  chk({31'd0, ocupado_leit[0]});
        push("x2_free",     32'h0);  chk({31'd0, ocupado_leit[1]});
        push("x2_value",    32'h2);  chk(d1());

        // Requests made while reset is held are ignored.
        sinal_rst_n = 1'b0;
        hab_esc0 = 1'b1; dest_esc0 = 5'd2; dado_esc0 = 32'h77777777;
        hab_reserva = 1'b1; dest_reserva = 5'd2;
        tick(); idle();
        sinal_rst_n = 1'b1; #1;
        push("held_rst_dado", 32'h0); chk(d1());
        push("held_rst_ocup", 32'h0); chk({31'd0, ocupado_leit[1]});
        push("held_rst_num",  32'h0); chk(num());

        if (sb.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL scoreboard_leftover: observed %0d entries expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/banco_reg_param.md
Name: banco_reg_param

Overview:
- Parametrised successor to the RV32I register file: configurable data width, register count and number of read ports.
- Two write ports with fixed priority, plus a busy scoreboard per register for pipelined hazard detection.
- Sits between decode (read/reserve) and writeback (write/release) in the pipelined core.
- Register 0 is hardwired to zero and is never marked busy.

Parameters:
- LARG_DADO, 32, data width in bits.
- NUM_REGS, 32, number of registers; power of two, at least 2.
- NUM_LEIT, 2, number of combinational read ports; range 1 to 4.
- Localparam LARG_END = $clog2(NUM_REGS), address width.

Ports:
- sinal_clk  in  1  clock; all writes, reserves and releases are sampled on the rising edge.
- sinal_rst_n  in  1  asynchronous active-low reset.
- sel_leit  in  NUM_LEIT*LARG_END  read selectors; port k uses bits [k*LARG_END +: LARG_END].
- dado_leit  out  NUM_LEIT*LARG_DADO  read data; port k uses bits [k*LARG_DADO +: LARG_DADO].
- ocupado_leit  out  NUM_LEIT  busy flag of the register selected on each read port.
- hab_esc0  in  1  write-enable, port 0.
- dest_esc0  in  LARG_END  destination register, port 0.
- dado_esc0  in  LARG_DADO  write data, port 0.
- hab_esc1  in  1  write-enable, port 1 (higher priority).
- dest_esc1  in  LARG_END  destination register, port 1.
- dado_esc1  in  LARG_DADO  write data, port 1.
- hab_reserva  in  1  mark dest_reserva busy (decode issue).
- dest_reserva  in  LARG_END  register to reserve.
- num_ocupados  out  LARG_END+1  count of busy registers.

Behaviour:
- Reset (sinal_rst_n=0, asynchronous): all registers cleared to 0, all busy bits cleared, num_ocupados=0. The clear takes effect immediately regardless of the clock. Write, reserve and release requests are ignored while reset is held. Deassertion is synchronised externally.
- Read path (combinational):
  - dado_leit[k] = 0 and ocupado_leit[k] = 0 when sel_leit[k] = 0.
  - Otherwise dado_leit[k] shows the stored value and ocupado_leit[k] shows the busy bit.
- Write (rising edge): a port writes when its hab is 1 and its dest is not 0.
  - If both ports target the same register, port 1's data is stored and port 0 is dropped.
  - Writes to register 0 are discarded.
- Release: each effective write clears the busy bit of its destination.
- Reserve: on a rising edge with hab_reserva=1 and dest_reserva not 0, the busy bit of dest_reserva is set.
  - If the same edge also releases that register, reserve wins and the bit ends at 1 (a new producer has issued).
  - Reserving an already-busy register leaves it busy; no count change.
- num_ocupados:
  - Registered; always equals the population count of the busy bits after each edge.
  - Per-edge delta lies between -2 and +1.
  - The counter never wraps; its maximum is NUM_REGS-1.
- Latency: a write or reserve is visible on the read outputs from the cycle after the edge. Without the optional feature there is no same-cycle forwarding.

Optional Feature:
- Macro: BANCO_REG_BYPASS_EN.
- Defined: write-to-read forwarding. If a read port's selector (not 0) matches an effective write in the current cycle, dado_leit returns the write data combinationally (port 1 takes priority over port 0), and ocupado_leit reads 0 unless a reserve to the same register is active in that cycle.
- Undefined: reads return stored state only, as described under Behaviour.

Test Plan:
- Reset: write x5=0xDEADBEEF, then pulse sinal_rst_n low mid-cycle -> dado_leit for x5 is 0 immediately, before the next edge; num_ocupados=0.
- x0 protection: hab_esc0=1, dest_esc0=0, dado=0xFFFFFFFF, then read x0 -> reads 0; ocupado_leit=0.
- Collision: both ports write x7 on one edge, port 0 0x11111111 and port 1 0x22222222 -> x7 reads 0x22222222.
- Scoreboard: reserve x3 and x4 -> num_ocupados=2. Then write x3 on port 0 and reserve x3 on the same edge -> x3 stays busy; num_ocupados=2.
- Release both: write x3 and x4 on the same edge via ports 0 and 1 -> num_ocupados drops by 2 to 0; both ocupado_leit flags are 0.
- Bypass (macro defined): read x9 while port 0 writes 0xCAFEF00D to x9 -> dado_leit=0xCAFEF00D in the same cycle. Macro undefined -> returns the old value until the next cycle.
